io_pattern_sequencer: RTL
=========================

# io_pattern_sequencer

Synthesizable controller that plays a programmed table of (value, hold) steps onto a WIDTH-bit io bus. It is the drive source for the io lines that the io VIP monitors in testbenches. It replaces per-cycle test-side pokes with a self-timed, cycle-exact pattern. Software or a bench loads the table, issues `start`, and the block sequences the bus and then returns it to an idle level.

## Interface
- `WIDTH`, 8, io bus width.
- `DEPTH`, 16, table entries (power of two, ≥2).
- `CNT_WIDTH`, 16, width of the per-step hold field.
- `AW`, $clog2(DEPTH), table address width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `cfg_wr_en`  in  1  table write strobe.
- `cfg_wr_addr`  in  AW  table entry index.
- `cfg_wr_value`  in  WIDTH  io value for the entry.
- `cfg_wr_hold`  in  CNT_WIDTH  extra hold cycles; the entry lasts hold+1 cycles.
- `cfg_len`  in  AW+1  number of active entries, 0..DEPTH; sampled at start.
- `cfg_loops`  in  8  additional passes; present only with IO_SEQ_LOOP_EN.
- `idle_value`  in  WIDTH  level driven when not running.
- `start`  in  1  begin playback (level, sampled per cycle).
- `stop`  in  1  abort playback.
- `io_o`  out  WIDTH  registered io bus.
- `busy`  out  1  high while running.
- `done`  out  1  one-cycle pulse on normal completion.
- `err`  out  1  one-cycle pulse on a rejected command.
- `step_idx`  out  AW  index of the entry currently driven.

## Operation
- States: IDLE and RUN.
- IDLE:
  - `io_o` <= `idle_value` every cycle.
  - `step_idx` = 0.
- IDLE → RUN: `start`=1, `stop`=0 and `cfg_len`≠0.
  - Latch `cfg_len`, load the hold counter with entry 0's hold, and set `io_o` <= entry0.value.
- IDLE with `start` and `cfg_len`=0: stay in IDLE and pulse `err`.
- RUN:
  - The hold counter decrements each cycle.
  - At 0, if `step_idx` < len-1: advance `step_idx`, load the next entry's value and hold.
  - At 0 on the last entry: go to IDLE, set `io_o` <= `idle_value`, and pulse `done` in that same cycle.
- `stop` in RUN has priority over everything.
  - Next cycle: IDLE, `io_o` = `idle_value`, no `done`.
- `start` in RUN is ignored, with no `err`.
- `start`+`stop` together in IDLE: stop wins, so nothing starts and there is no `err`.
- Table writes:
  - Accepted only in IDLE; the table is register-based, 1-cycle write.
  - `cfg_wr_en` in RUN is dropped and pulses `err`.
  - A write and a start in the same IDLE cycle: the write lands, and the start uses the old contents at that address.
- `cfg_len` > DEPTH is clamped to DEPTH.
- Hold counter arithmetic is unsigned CNT_WIDTH. Hold = all-ones gives 2^CNT_WIDTH cycles, with no wrap glitch.
- Table contents are not reset. Reads of unwritten entries return X in simulation; benches must load before start.

## Timing
- Reset values: `io_o`=0, `busy`=0, `done`=0, `err`=0, `step_idx`=0, state IDLE.
- From the first post-reset cycle, `io_o` follows `idle_value` with 1-cycle latency.
- Start latency:
  - `start` sampled at edge N; `io_o`=entry0 and `busy`=1 after edge N.
  - Entry k is visible for exactly hold_k+1 cycles.
- Total RUN length for one pass is Σ(hold_k+1) cycles.
  - `busy` deasserts and `done` pulses on the edge after the last cycle.
  - Back-to-back `start` is accepted on the cycle `done` is high, with no extra idle cycle required.
- `resetn` low mid-run: outputs take their reset values asynchronously. The table is retained.

## Configuration
- `IO_SEQ_LOOP_EN` defined:
  - The `cfg_loops` port exists and is sampled at start.
  - After the last entry, if the remaining-loop count ≠ 0, decrement it and wrap to entry 0 with no idle gap.
  - Total passes = `cfg_loops`+1.
  - `stop` aborts at any pass.
- Not defined:
  - There is no `cfg_loops` port; the block plays exactly one pass.
  - The loop counter logic is absent.

## Test plan
- Reset, then `idle_value`=0xA5: `io_o`=0x00 during reset and 0xA5 one cycle after release; `busy`=0.
- Load {0x11 hold 0, 0x22 hold 2, 0x33 hold 1}, `cfg_len`=3, start:
  - `io_o` = 0x11×1, 0x22×3, 0x33×2, then `idle_value`.
  - `done` pulses on the return to idle; `busy` is high for 6 cycles.
- `stop` asserted on the 2nd cycle of 0x22: `io_o` = `idle_value` next cycle, with no `done` and no `err`.
- `cfg_len`=0 with start: `err` pulse, `busy` stays 0. A `cfg_wr_en` during RUN: `err` pulse, and the table is unchanged on replay.
- With IO_SEQ_LOOP_EN, `cfg_loops`=2, 2 entries of hold 0 each: 6 cycles alternating values with no idle gap, then a single `done`.
- Hold=0xFFFF on one entry: held exactly 65536 cycles. Assert `resetn` low mid-hold: `io_o`=0 immediately, and the table replays intact after restart.

Source files
------------

// File: rtl/io_pattern_sequencer.sv
// Plays a table of (value, hold) steps onto an io bus, then returns it to idle_value.
// Define IO_SEQ_LOOP_EN to add the cfg_loops port and repeat the whole table cfg_loops extra times.
module io_pattern_sequencer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cfg_wr_en,
  input  logic [$clog2(DEPTH)-1:0] cfg_wr_addr,
  input  logic [WIDTH-1:0]         cfg_wr_value,
  input  logic [CNT_WIDTH-1:0]     cfg_wr_hold,
  input  logic [$clog2(DEPTH):0]   cfg_len,
`ifdef IO_SEQ_LOOP_EN
  input  logic [7:0]               cfg_loops,
`endif
  input  logic [WIDTH-1:0]         idle_value,
  input  logic                     start,
  input  logic                     stop,
  output logic [WIDTH-1:0]         io_o,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH)-1:0] step_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] MaxLen = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     io_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [AW-1:0]        step_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [AW:0]          len_q;
`ifdef IO_SEQ_LOOP_EN
  logic [7:0]           loops_q;
`endif

  logic [WIDTH-1:0]     tbl_val_q  [DEPTH];
  logic [CNT_WIDTH-1:0] tbl_hold_q [DEPTH];

  logic [AW:0]   len_d;
  logic [AW-1:0] next_idx_d;
  logic          last_step;

  always_comb begin
    len_d      = (cfg_len > MaxLen) ? MaxLen : cfg_len;
    next_idx_d = step_q + 1'b1;
    last_step  = ({1'b0, step_q} == (len_q - 1'b1));
  end

  // The table is deliberately left out of reset so it survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && state_q == IDLE) begin
      tbl_val_q[cfg_wr_addr]  <= cfg_wr_value;
      tbl_hold_q[cfg_wr_addr] <= cfg_wr_hold;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      io_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      step_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
`ifdef IO_SEQ_LOOP_EN
      loops_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          io_q   <= idle_value;
          step_q <= '0;
          if (start && !stop) begin
            if (cfg_len == '0) begin
              err_q <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              len_q   <= len_d;
              cnt_q   <= tbl_hold_q[0];
              io_q    <= tbl_val_q[0];
`ifdef IO_SEQ_LOOP_EN
              loops_q <= cfg_loops;
`endif
            end
          end
        end
        RUN: begin
          if (cfg_wr_en) err_q <= 1'b1;
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            io_q    <= idle_value;
            step_q  <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!last_step) begin
            step_q <= next_idx_d;
            cnt_q  <= tbl_hold_q[next_idx_d];
            io_q   <= tbl_val_q[next_idx_d];
`ifdef IO_SEQ_LOOP_EN
          end else if (loops_q != '0) begin
            loops_q <= loops_q - 1'b1;
            step_q  <= '0;
            cnt_q   <= tbl_hold_q[0];
            io_q    <= tbl_val_q[0];
`endif
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            io_q    <= idle_value;
            step_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_o     = io_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign step_idx = step_q;

endmodule
